// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame FSM states and the
// bit-period calculation used by every UART block.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_t;

   // Clock cycles per serial bit, truncated toward zero.
   function automatic int calc_div(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: shifts one byte out LSB first between a start and a
// stop bit, each bit lasting DIV clock cycles.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DIV = 868
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

   uart_state_t state, state_next;
   logic [CW-1:0] bit_cnt, bit_cnt_next;
   logic [2:0]    idx, idx_next;
   logic [7:0]    shift, shift_next;
   logic          tx_next, busy_next;
   logic          bit_end;

   assign bit_end = (bit_cnt == LAST_CNT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         bit_cnt <= '0;
         idx     <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         idx     <= idx_next;
         shift   <= shift_next;
         tx      <= tx_next;
         busy    <= busy_next;
      end
   end

   // The next line level is computed here so that tx and busy come straight
   // from flops; counters only move inside a bit and clear on each transition.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      idx_next     = idx;
      shift_next   = shift;
      tx_next      = tx;
      busy_next    = busy;
      unique case (state)
         ST_IDLE: begin
            tx_next      = 1'b1;
            bit_cnt_next = '0;
            idx_next     = '0;
            if (start) begin
               state_next = ST_START;
               shift_next = data;
               tx_next    = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               bit_cnt_next = '0;
               state_next   = ST_DATA;
               tx_next      = shift[0];
               shift_next   = {1'b0, shift[7:1]};
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_cnt_next = '0;
               if (idx == 3'd7) begin
                  state_next = ST_STOP;
                  idx_next   = '0;
                  tx_next    = 1'b1;
               end else begin
                  idx_next   = idx + 3'd1;
                  tx_next    = shift[0];
                  shift_next = {1'b0, shift[7:1]};
               end
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               bit_cnt_next = '0;
               state_next   = ST_IDLE;
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      busy_next = (state_next != ST_IDLE);
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N_REQ byte requesters into one UART transmitter;
// a byte is accepted only while the line is idle.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int N_REQ      = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         io_req_valid,
   output logic [N_REQ-1:0]         io_req_ready,
   input  logic [8*N_REQ-1:0]       io_req_bits,
   output logic                     io_tx,
   output logic                     io_busy,
   output logic [$clog2(N_REQ)-1:0] io_grant_id
);

   localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
   localparam int IDW = $clog2(N_REQ);

   if (DIV < 2) begin : g_div_check
      $error("uart_tx_arbiter: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end
   if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_check
      $error("uart_tx_arbiter: N_REQ must be in 2..8");
   end

   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] winner;
   logic           found;
   logic           accept;
   logic           ser_busy;
   int             cand;

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(last_grant) + i) % N_REQ;
         if (!found && io_req_valid[cand]) begin
            found  = 1'b1;
            winner = IDW'(cand);
         end
      end
   end

   // Reset is folded in so ready is silent while reset is held.
   always_comb begin
      io_req_ready = '0;
      if (reset && !ser_busy && found) begin
         io_req_ready[winner] = 1'b1;
      end
   end

   assign accept = |io_req_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant  <= IDW'(N_REQ - 1);
         io_grant_id <= '0;
      end else if (accept) begin
         last_grant  <= winner;
         io_grant_id <= winner;
      end
   end

   uart_tx_serializer #(
      .DIV(DIV)
   ) u_serializer (
      .clock(clock),
      .reset(reset),
      .start(accept),
      .data (io_req_bits[8*winner +: 8]),
      .tx   (io_tx),
      .busy (ser_busy)
   );

   assign io_busy = ser_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a default-rate instance and a fast
// (DIV=8) instance, checked against a round-robin queue model and a line decoder.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int DIV_A = 100_000_000 / 115200;
   localparam int DIV_B = 100_000_000 / 12_500_000;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   va, vb, ra, rb;
   logic [8*N-1:0] ba, bb;
   logic           txa, txb, busya, busyb;
   logic [1:0]     gida, gidb;

   always #5 clock = ~clock;

   uart_tx_arbiter dut_a (
      .clock(clock), .reset(reset), .io_req_valid(va), .io_req_ready(ra),
      .io_req_bits(ba), .io_tx(txa), .io_busy(busya), .io_grant_id(gida)
   );

   uart_tx_arbiter #(.BAUD_RATE(12_500_000)) dut_b (
      .clock(clock), .reset(reset), .io_req_valid(vb), .io_req_ready(rb),
      .io_req_bits(bb), .io_tx(txb), .io_busy(busyb), .io_grant_id(gidb)
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] pend [N][$];
   logic       cap_tx[$];
   logic       cap_busy[$];
   logic [1:0] cap_gid[$];
   int         acc_idx[$];
   int         acc_id[$];
   int         bad_ready, rdy_cycles;
   int         exp_id[$];
   logic [7:0] exp_byte[$];
   int         dec_start[$], dec_bad[$], dec_gid[$];
   logic [7:0] dec_byte[$];
   int         busy_bad;
   int         ptr_a, ptr_b;

   // Drive requester queues into one instance and record its outputs per cycle.
   task automatic step_cycles(input bit fast, input int n);
      logic [N-1:0]   v, r;
      logic [8*N-1:0] b;
      cap_tx.delete(); cap_busy.delete(); cap_gid.delete();
      acc_idx.delete(); acc_id.delete();
      bad_ready = 0; rdy_cycles = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         v = '0; b = '0;
         for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) begin
               v[i] = 1'b1;
               b[8*i +: 8] = pend[i][0];
            end
         end
         if (fast) begin vb = v; bb = b; va = '0; end
         else begin va = v; ba = b; vb = '0; end
         #1;
         r = fast ? rb : ra;
         cap_tx.push_back(fast ? txb : txa);
         cap_busy.push_back(fast ? busyb : busya);
         cap_gid.push_back(fast ? gidb : gida);
         if (r != '0) rdy_cycles++;
         if ($countones(r) > 1 || (r & ~v) != '0) bad_ready++;
         for (int i = 0; i < N; i++) begin
            if (r[i] && v[i]) begin
               acc_idx.push_back(c);
               acc_id.push_back(i);
               void'(pend[i].pop_front());
            end
         end
      end
   endtask

   // Expected service order: repeatedly take the first non-empty queue after the pointer.
   function automatic void rr_model(input int ptr_in, output int ptr_out);
      logic [7:0] mq [N][$];
      int p, remaining, idx;
      bit hit;
      exp_id.delete(); exp_byte.delete();
      remaining = 0;
      for (int i = 0; i < N; i++) begin
         mq[i] = pend[i];
         remaining += mq[i].size();
      end
      p = ptr_in;
      while (remaining > 0) begin
         hit = 1'b0;
         for (int k = 1; k <= N; k++) begin
            idx = (p + k) % N;
            if (!hit && mq[idx].size() != 0) begin
               hit = 1'b1;
               exp_id.push_back(idx);
               exp_byte.push_back(mq[idx].pop_front());
               p = idx;
               remaining--;
            end
         end
      end
      ptr_out = p;
   endfunction

   // Split the captured line into 8N1 frames, counting any sample off its ideal level.
   function automatic void decode_all(input int div);
      int pos, s, bad;
      logic [7:0] b;
      logic v;
      dec_start.delete(); dec_bad.delete(); dec_gid.delete(); dec_byte.delete();
      busy_bad = 0;
      pos = 0;
      while (pos < cap_tx.size()) begin
         if (cap_tx[pos] == 1'b0 && pos + 10*div <= cap_tx.size()) begin
            s = pos; bad = 0; b = '0;
            for (int k = 0; k < 10; k++) begin
               v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cap_tx[s + k*div + div/2];
               if (k >= 1 && k <= 8) b[k-1] = v;
               for (int j = 0; j < div; j++) begin
                  if (cap_tx[s + k*div + j] !== v) bad++;
                  if (cap_busy[s + k*div + j] !== 1'b1) bad++;
                  if (cap_gid[s + k*div + j] !== cap_gid[s]) bad++;
               end
            end
            dec_start.push_back(s); dec_bad.push_back(bad);
            dec_gid.push_back(int'(cap_gid[s])); dec_byte.push_back(b);
            pos = s + 10*div;
         end else begin
            if (cap_tx[pos] == 1'b0) begin
               dec_start.push_back(pos); dec_bad.push_back(1);
               dec_gid.push_back(-1); dec_byte.push_back(8'h00);
            end
            if (cap_busy[pos] !== 1'b0) busy_bad++;
            pos++;
         end
      end
   endfunction

   task automatic test_reset;
      reset = 1'b1; va = '1; vb = '1; ba = '0; bb = '0;
      #3 reset = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      n_cmp++; if (txa !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx_a: got %b want 1", txa); end
      n_cmp++; if (busya !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy_a: got %b want 0", busya); end
      n_cmp++; if (ra !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready_a: got %b want 0000", ra); end
      n_cmp++; if (gida !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_gid_a: got %0d want 0", gida); end
      n_cmp++; if (txb !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx_b: got %b want 1", txb); end
      n_cmp++; if (rb !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready_b: got %b want 0000", rb); end
      ptr_a = N - 1; ptr_b = N - 1;
      @(negedge clock);
      va = '0; vb = '0;
      reset = 1'b1;
   endtask

   task automatic test_single_byte;
      int s, low_run;
      pend[0].push_back(8'h41);
      step_cycles(1'b0, 1 + 10*DIV_A + 5);
      ptr_a = 0;
      n_cmp++; if (acc_id.size() !== 1) begin n_fail++; $display("[TB] FAIL single_accepts: got %0d want 1", acc_id.size()); end
      n_cmp++; if (rdy_cycles !== 1) begin n_fail++; $display("[TB] FAIL single_ready_cycles: got %0d want 1", rdy_cycles); end
      s = (acc_idx.size() != 0) ? acc_idx[0] + 1 : 0;
      low_run = 0;
      for (int j = s; j < cap_tx.size() && cap_tx[j] == 1'b0; j++) low_run++;
      n_cmp++; if (low_run !== DIV_A) begin n_fail++; $display("[TB] FAIL single_start_len: got %0d want %0d", low_run, DIV_A); end
      decode_all(DIV_A);
      n_cmp++; if (dec_byte.size() !== 1) begin n_fail++; $display("[TB] FAIL single_frames: got %0d want 1", dec_byte.size()); end
      if (dec_byte.size() != 0) begin
         n_cmp++; if (dec_byte[0] !== 8'h41) begin n_fail++; $display("[TB] FAIL single_byte: got %h want 41", dec_byte[0]); end
         n_cmp++; if (dec_bad[0] !== 0) begin n_fail++; $display("[TB] FAIL single_timing: got %0d bad samples want 0", dec_bad[0]); end
         n_cmp++; if (dec_start[0] !== s) begin n_fail++; $display("[TB] FAIL single_latency: got start %0d want %0d", dec_start[0], s); end
         n_cmp++; if (dec_gid[0] !== 0) begin n_fail++; $display("[TB] FAIL single_gid: got %0d want 0", dec_gid[0]); end
      end
      n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("[TB] FAIL single_busy_idle: got %0d bad want 0", busy_bad); end
   endtask

   task automatic test_contention;
      for (int i = 0; i < N; i++) pend[i].push_back(8'h41 + 8'(i));
      rr_model(ptr_b, ptr_b);
      step_cycles(1'b1, N*(10*DIV_B + 1) + 10);
      decode_all(DIV_B);
      n_cmp++; if (dec_byte.size() !== exp_byte.size()) begin n_fail++; $display("[TB] FAIL cont_frames: got %0d want %0d", dec_byte.size(), exp_byte.size()); end
      for (int k = 0; k < exp_byte.size() && k < dec_byte.size(); k++) begin
         n_cmp++; if (dec_byte[k] !== exp_byte[k]) begin n_fail++; $display("[TB] FAIL cont_byte[%0d]: got %h want %h", k, dec_byte[k], exp_byte[k]); end
         n_cmp++; if (dec_gid[k] !== exp_id[k]) begin n_fail++; $display("[TB] FAIL cont_gid[%0d]: got %0d want %0d", k, dec_gid[k], exp_id[k]); end
         n_cmp++; if (dec_bad[k] !== 0) begin n_fail++; $display("[TB] FAIL cont_timing[%0d]: got %0d bad want 0", k, dec_bad[k]); end
         if (k > 0) begin
            n_cmp++; if (dec_start[k] - dec_start[k-1] !== 10*DIV_B + 1) begin n_fail++; $display("[TB] FAIL cont_gap[%0d]: got %0d want %0d", k, dec_start[k] - dec_start[k-1], 10*DIV_B + 1); end
         end
      end
      n_cmp++; if (bad_ready !== 0 || busy_bad !== 0) begin n_fail++; $display("[TB] FAIL cont_ready_busy: got %0d/%0d want 0/0", bad_ready, busy_bad); end
   endtask

   task automatic test_wrap;
      pend[0].push_back(8'h30);
      pend[2].push_back(8'h32);
      rr_model(ptr_b, ptr_b);
      step_cycles(1'b1, 2*(10*DIV_B + 1) + 10);
      decode_all(DIV_B);
      n_cmp++; if (dec_byte.size() !== 2) begin n_fail++; $display("[TB] FAIL wrap_frames: got %0d want 2", dec_byte.size()); end
      for (int k = 0; k < exp_byte.size() && k < dec_byte.size(); k++) begin
         n_cmp++; if (dec_gid[k] !== exp_id[k]) begin n_fail++; $display("[TB] FAIL wrap_gid[%0d]: got %0d want %0d", k, dec_gid[k], exp_id[k]); end
         n_cmp++; if (dec_byte[k] !== exp_byte[k]) begin n_fail++; $display("[TB] FAIL wrap_byte[%0d]: got %h want %h", k, dec_byte[k], exp_byte[k]); end
      end
   endtask

   task automatic test_fast_ff;
      int zeros, ones, busy_ones, s;
      pend[3].push_back(8'hFF);
      rr_model(ptr_b, ptr_b);
      step_cycles(1'b1, 10*DIV_B + 10);
      decode_all(DIV_B);
      zeros = 0; ones = 0; busy_ones = 0;
      s = (acc_idx.size() != 0) ? acc_idx[0] + 1 : 0;
      for (int j = s; j < s + 10*DIV_B && j < cap_tx.size(); j++) begin
         if (cap_tx[j] == 1'b0) zeros++; else ones++;
      end
      foreach (cap_busy[j]) if (cap_busy[j] == 1'b1) busy_ones++;
      n_cmp++; if (zeros !== 8) begin n_fail++; $display("[TB] FAIL ff_low_cycles: got %0d want 8", zeros); end
      n_cmp++; if (ones !== 72) begin n_fail++; $display("[TB] FAIL ff_high_cycles: got %0d want 72", ones); end
      n_cmp++; if (busy_ones !== 80) begin n_fail++; $display("[TB] FAIL ff_frame_len: got %0d want 80", busy_ones); end
      n_cmp++; if (dec_byte.size() !== 1 || (dec_byte.size() == 1 && dec_byte[0] !== 8'hFF)) begin n_fail++; $display("[TB] FAIL ff_byte: got %0d frames want one 0xFF", dec_byte.size()); end
   endtask

   task automatic test_random;
      int total;
      for (int round = 0; round < 6; round++) begin
         total = 0;
         for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = $urandom_range(0, 3);
            for (int j = 0; j < cnt; j++) pend[i].push_back(8'($urandom));
            total += cnt;
         end
         rr_model(ptr_b, ptr_b);
         step_cycles(1'b1, total*(10*DIV_B + 1) + 12);
         decode_all(DIV_B);
         n_cmp++; if (dec_byte.size() !== total) begin n_fail++; $display("[TB] FAIL rand%0d_frames: got %0d want %0d", round, dec_byte.size(), total); end
         for (int k = 0; k < exp_byte.size() && k < dec_byte.size(); k++) begin
            n_cmp++; if (dec_byte[k] !== exp_byte[k] || dec_gid[k] !== exp_id[k]) begin n_fail++; $display("[TB] FAIL rand%0d_frame[%0d]: got %h/id%0d want %h/id%0d", round, k, dec_byte[k], dec_gid[k], exp_byte[k], exp_id[k]); end
            n_cmp++; if (dec_bad[k] !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_timing[%0d]: got %0d bad want 0", round, k, dec_bad[k]); end
            if (k > 0) begin
               n_cmp++; if (dec_start[k] - dec_start[k-1] !== 10*DIV_B + 1) begin n_fail++; $display("[TB] FAIL rand%0d_gap[%0d]: got %0d want %0d", round, k, dec_start[k] - dec_start[k-1], 10*DIV_B + 1); end
            end
         end
         n_cmp++; if (bad_ready !== 0 || busy_bad !== 0) begin n_fail++; $display("[TB] FAIL rand%0d_ready_busy: got %0d/%0d want 0/0", round, bad_ready, busy_bad); end
      end
   endtask

   task automatic test_reset_mid_frame;
      pend[1].push_back(8'($urandom));
      step_cycles(1'b0, 3000);
      n_cmp++; if (acc_id.size() !== 1 || (acc_id.size() == 1 && acc_id[0] !== 1)) begin n_fail++; $display("[TB] FAIL midrst_grant: got %0d grants want one to req1", acc_id.size()); end
      n_cmp++; if (busya !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_busy_before: got %b want 1", busya); end
      va = 4'b1111;
      #1 reset = 1'b0;
      #1;
      n_cmp++; if (txa !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_tx: got %b want 1", txa); end
      n_cmp++; if (busya !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b want 0", busya); end
      n_cmp++; if (ra !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b want 0000", ra); end
      n_cmp++; if (gida !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_gid: got %0d want 0", gida); end
      ptr_a = N - 1; ptr_b = N - 1;
      @(negedge clock);
      reset = 1'b1;
      va = 4'b0010; ba = {8'h00, 8'h00, 8'h5A, 8'h00};
      #1;
      n_cmp++; if (ra !== 4'b0010) begin n_fail++; $display("[TB] FAIL midrst_req1_alone: got %b want 0010", ra); end
      n_cmp++; if (txa !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_abandoned: got %b want 1", txa); end
      va = 4'b0101; ba = {8'h00, 8'h33, 8'h00, 8'h11};
      #1;
      n_cmp++; if (ra !== 4'b0001) begin n_fail++; $display("[TB] FAIL midrst_ptr_restored: got %b want 0001", ra); end
      @(negedge clock);
      va = '0;
      #1;
      n_cmp++; if (txa !== 1'b0 || busya !== 1'b1 || gida !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_new_frame: got tx%b busy%b gid%0d want tx0 busy1 gid0", txa, busya, gida); end
   endtask

   task automatic test_idle;
      int tx_bad, bsy_bad;
      step_cycles(1'b1, 10000);
      tx_bad = 0; bsy_bad = 0;
      foreach (cap_tx[j]) begin
         if (cap_tx[j] !== 1'b1) tx_bad++;
         if (cap_busy[j] !== 1'b0) bsy_bad++;
      end
      n_cmp++; if (tx_bad !== 0) begin n_fail++; $display("[TB] FAIL idle_tx: got %0d low cycles want 0", tx_bad); end
      n_cmp++; if (bsy_bad !== 0) begin n_fail++; $display("[TB] FAIL idle_busy: got %0d busy cycles want 0", bsy_bad); end
      n_cmp++; if (rdy_cycles !== 0) begin n_fail++; $display("[TB] FAIL idle_ready: got %0d ready cycles want 0", rdy_cycles); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_contention();
      test_wrap();
      test_fast_ff();
      test_random();
      test_reset_mid_frame();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
